// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types for the ALU execution unit: the decoded operation enum, the
// FSM state enum, the decoded function-field codes and a small helper that
// tells the datapath which operations go through the iterative shifter.
//
// Optional feature macro: ALU_MUL_EN (see alu_decode / alu_exec_unit).

package alu_pkg;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    AND,
    OR,
    XOR,
    NOR,
    SLT,
    SLTU,
    SLL,
    SRL,
    SRA,
    LUI,
    MUL,
    ILL
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_e;

  localparam logic [3:0] FUNCT_ADD  = 4'b0000;
  localparam logic [3:0] FUNCT_SUB  = 4'b0010;
  localparam logic [3:0] FUNCT_AND  = 4'b0100;
  localparam logic [3:0] FUNCT_OR   = 4'b0101;
  localparam logic [3:0] FUNCT_XOR  = 4'b0110;
  localparam logic [3:0] FUNCT_NOR  = 4'b0111;
  localparam logic [3:0] FUNCT_MUL  = 4'b1000;
  localparam logic [3:0] FUNCT_SLT  = 4'b1010;
  localparam logic [3:0] FUNCT_SLTU = 4'b1011;
  localparam logic [3:0] FUNCT_SLL  = 4'b1100;
  localparam logic [3:0] FUNCT_SRL  = 4'b1101;
  localparam logic [3:0] FUNCT_SRA  = 4'b1110;
  localparam logic [3:0] FUNCT_LUI  = 4'b1111;

  // Shifts share the one-bit-per-cycle shifter, so the FSM needs to know
  // whether an accepted op may have to go through BUSY.
  function automatic logic isShift(input alu_op_e op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode
// Purely combinational ALU-control decoder: main-decoder class plus the
// function field become one alu_op_e value for the execution unit.
//
// Ports:
//   aluOp_i  [1:0]  00 add (loads/stores), 01 sub (branches), 1x use funct
//   funct_i  [5:0]  function field; only bits [3:0] carry meaning
//   op_o            decoded operation (ILL for unsupported codes)
//
// Optional feature macro: ALU_MUL_EN. When undefined, funct 1000 decodes
// to ILL so the execution unit never sees MUL.

module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [5:0] funct_i,
  output alu_op_e    op_o
);

  // The top two function bits are not part of the ALU-control table.
  logic unusedFunctBits;
  assign unusedFunctBits = ^funct_i[5:4];

  // Loads/stores and branches bypass the function field entirely; R-type
  // instructions look up the low nibble, anything unlisted is illegal.
  always_comb begin
    op_o = ILL;
    if (!aluOp_i[1]) begin
      op_o = aluOp_i[0] ? SUB : ADD;
    end else begin
      case (funct_i[3:0])
        FUNCT_ADD:  op_o = ADD;
        FUNCT_SUB:  op_o = SUB;
        FUNCT_AND:  op_o = AND;
        FUNCT_OR:   op_o = OR;
        FUNCT_XOR:  op_o = XOR;
        FUNCT_NOR:  op_o = NOR;
        FUNCT_SLT:  op_o = SLT;
        FUNCT_SLTU: op_o = SLTU;
        FUNCT_SLL:  op_o = SLL;
        FUNCT_SRL:  op_o = SRL;
        FUNCT_SRA:  op_o = SRA;
        FUNCT_LUI:  op_o = LUI;
`ifdef ALU_MUL_EN
        FUNCT_MUL:  op_o = MUL;
`else
        FUNCT_MUL:  op_o = ILL;
`endif
        default:    op_o = ILL;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Multi-cycle ALU execution unit. Single-cycle ops are computed straight
// from the operands at the accept edge; shifts move one bit per cycle and
// the optional multiply is a shift-add loop of WIDTH steps. Operands come
// in and results go out through valid/ready handshakes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   alu_op, funct         ALU-control inputs
//   a, b                  operands; shift amount is b[SHW-1:0]
//   out_valid / out_ready result handshake
//   result, zero          registered result and its zero flag
//   illegal               unsupported funct code, valid with out_valid
//
// Optional feature macro: ALU_MUL_EN enables the iterative multiplier.

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_e       state_q;
  alu_op_e          op_q;
  alu_op_e          decOp;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             illegal_q;
  logic [WIDTH-1:0] singleRes;
  logic [WIDTH-1:0] busyNext;
  logic [SHW-1:0]   shamt;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
`endif

  alu_decode u_decode (
    .aluOp_i (alu_op),
    .funct_i (funct),
    .op_o    (decOp)
  );

  assign shamt = b[SHW-1:0];

  // One step of the iterative shifter; SRA replicates the sign bit.
  function automatic logic [WIDTH-1:0] shiftOne(input alu_op_e op,
                                                input logic [WIDTH-1:0] v);
    case (op)
      SLL:     return {v[WIDTH-2:0], 1'b0};
      SRL:     return {1'b0, v[WIDTH-1:1]};
      SRA:     return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  // Results of every op that finishes at the accept edge. Illegal codes
  // (and MUL when the multiplier is not built) fall through to zero.
  always_comb begin
    singleRes = '0;
    case (decOp)
      ADD:  singleRes = a + b;
      SUB:  singleRes = a - b;
      AND:  singleRes = a & b;
      OR:   singleRes = a | b;
      XOR:  singleRes = a ^ b;
      NOR:  singleRes = ~(a | b);
      SLT:  singleRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU: singleRes = {{(WIDTH-1){1'b0}}, (a < b)};
      LUI:  singleRes = b << (WIDTH / 2);
      default: singleRes = '0;
    endcase
  end

  // Value the work register takes on the next BUSY step.
  always_comb begin
`ifdef ALU_MUL_EN
    if (op_q == MUL) begin
      busyNext = work_q + (mplier_q[0] ? mcand_q : '0);
    end else begin
      busyNext = shiftOne(op_q, work_q);
    end
`else
    busyNext = shiftOne(op_q, work_q);
`endif
  end

  // Main FSM. The accept edge already performs the first shift/multiply
  // step, so a shift by k leaves BUSY after k-1 further steps and a
  // multiply after WIDTH-1; the counter holds the steps still to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= ADD;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= decOp;
            if (isShift(decOp)) begin
              if (shamt <= SHW'(1)) begin
                result_q  <= (shamt == '0) ? a : shiftOne(decOp, a);
                illegal_q <= 1'b0;
                state_q   <= DONE;
              end else begin
                work_q  <= shiftOne(decOp, a);
                cnt_q   <= shamt - SHW'(1);
                state_q <= BUSY;
              end
`ifdef ALU_MUL_EN
            end else if (decOp == MUL) begin
              work_q   <= b[0] ? a : '0;
              mcand_q  <= a << 1;
              mplier_q <= b >> 1;
              cnt_q    <= SHW'(WIDTH - 1);
              state_q  <= BUSY;
`endif
            end else begin
              result_q  <= singleRes;
              illegal_q <= (decOp == ILL);
              state_q   <= DONE;
            end
          end
        end

        BUSY: begin
`ifdef ALU_MUL_EN
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
`endif
          if (cnt_q == SHW'(1)) begin
            result_q  <= busyNext;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= DONE;
          end else begin
            work_q <= busyNext;
            cnt_q  <= cnt_q - SHW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

endmodule
